// File: rtl/vga_frame_scanner.sv
// Raster scanner for 640x480@60: reads the front frame buffer in raster order and drives RGB332 plus syncs.
// Also performs the front/back swap handshake at the start of vertical blanking.
module vga_frame_scanner #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              front_sel,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              frame_start,
  output logic [2:0]        vga_r,
  output logic [2:0]        vga_g,
  output logic [1:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  logic [DIV_W-1:0]  r_div;
  logic [H_W-1:0]    r_h_cnt;
  logic [V_W-1:0]    r_v_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_front_sel;
  logic              r_swap_ack;
  logic [RD_LAT-1:0] r_act_d;
  logic [RD_LAT-1:0] r_hs_d;
  logic [RD_LAT-1:0] r_vs_d;
  logic [7:0]        r_rgb;
  logic              r_hs;
  logic              r_vs;

  logic w_pix_ce;
  logic w_h_last;
  logic w_v_last;
  logic w_active;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_origin;
  logic w_swap;

  always_comb begin
    w_pix_ce = (r_div == DIV_W'(CLK_DIV - 1));
    w_h_last = (r_h_cnt == H_W'(H_TOTAL - 1));
    w_v_last = (r_v_cnt == V_W'(V_TOTAL - 1));
    w_active = (r_h_cnt < H_W'(H_ACTIVE)) && (r_v_cnt < V_W'(V_ACTIVE));
    w_hs_raw = !((r_h_cnt >= H_W'(H_ACTIVE + H_FP)) &&
                 (r_h_cnt <  H_W'(H_ACTIVE + H_FP + H_SYNC)));
    w_vs_raw = !((r_v_cnt >= V_W'(V_ACTIVE + V_FP)) &&
                 (r_v_cnt <  V_W'(V_ACTIVE + V_FP + V_SYNC)));
    w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    w_swap   = w_pix_ce && (r_h_cnt == '0) && (r_v_cnt == V_W'(V_ACTIVE)) && swap_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_rd_addr   <= '0;
      r_front_sel <= 1'b0;
      r_swap_ack  <= 1'b0;
      r_act_d     <= '0;
      r_hs_d      <= '1;
      r_vs_d      <= '1;
      r_rgb       <= '0;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
    end else begin
      r_div      <= w_pix_ce ? '0 : r_div + DIV_W'(1);
      r_swap_ack <= w_swap;
      if (w_swap)
        r_front_sel <= ~r_front_sel;
      if (w_pix_ce) begin
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + V_W'(1);
        end else begin
          r_h_cnt <= r_h_cnt + H_W'(1);
        end
        // Rewind on the last tick of the frame so the origin tick reads address 0.
        if (w_h_last && w_v_last)
          r_rd_addr <= '0;
        else if (w_active)
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
        r_act_d[0] <= w_active;
        r_hs_d[0]  <= w_hs_raw;
        r_vs_d[0]  <= w_vs_raw;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
          r_act_d[i] <= r_act_d[i-1];
          r_hs_d[i]  <= r_hs_d[i-1];
          r_vs_d[i]  <= r_vs_d[i-1];
        end
        r_rgb <= r_act_d[RD_LAT-1] ? rd_data : '0;
        r_hs  <= r_hs_d[RD_LAT-1];
        r_vs  <= r_vs_d[RD_LAT-1];
      end
    end
  end

  assign rd_en       = w_pix_ce && w_active;
  assign rd_addr     = r_rd_addr;
  assign frame_start = w_pix_ce && w_origin;
  assign front_sel   = r_front_sel;
  assign swap_ack    = r_swap_ack;
  assign vga_r       = r_rgb[7:5];
  assign vga_g       = r_rgb[4:2];
  assign vga_b       = r_rgb[1:0];
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner on a reduced raster, compared cycle by cycle against a tick-indexed reference model.
module tb_vga_frame_scanner;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int DIV = 2, LAT = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en;
  logic [18:0] rd_addr;
  logic [7:0]  rd_data = '0;
  logic        front_sel;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic        frame_start;
  logic [2:0]  vga_r, vga_g;
  logic [1:0]  vga_b;
  logic        vga_hs, vga_vs;

  vga_frame_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV), .RD_LAT(LAT), .ADDR_W(19)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .front_sel(front_sel), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_start(frame_start), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  always #10 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  mem [HA*VA];
  int          rec_addr [8];
  bit          rec_vld [8];
  bit          exp_front, exp_ack;
  int          c;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, c, $time);
    end
  endtask

  function automatic int h_of(input int n); return n % HT; endfunction
  function automatic int v_of(input int n); return (n / HT) % VT; endfunction
  function automatic bit act_of(input int n); return (h_of(n) < HA) && (v_of(n) < VA); endfunction

  task automatic model_reset();
    c = 0;
    exp_front = 1'b0;
    exp_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rec_vld[i] = 1'b0;
      rec_addr[i] = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, ".rd_en"}, 32'(rd_en), 32'd0);
    check_eq({tag, ".rd_addr"}, 32'(rd_addr), 32'd0);
    check_eq({tag, ".frame_start"}, 32'(frame_start), 32'd0);
    check_eq({tag, ".swap_ack"}, 32'(swap_ack), 32'd0);
    check_eq({tag, ".front_sel"}, 32'(front_sel), 32'd0);
    check_eq({tag, ".rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    check_eq({tag, ".hs"}, 32'(vga_hs), 32'd1);
    check_eq({tag, ".vs"}, 32'(vga_vs), 32'd1);
  endtask

  // Called mid-cycle: check this cycle's outputs, then drive this cycle's inputs.
  task automatic do_cycle(input bit rise);
    bit pce;
    int n, m, h, v, a;
    logic [7:0] px;
    pce = (c % DIV) == DIV - 1;
    n = c / DIV;
    if (pce) begin
      check_eq("rd_en", 32'(rd_en), 32'(act_of(n)));
      check_eq("frame_start", 32'(frame_start), 32'(h_of(n) == 0 && v_of(n) == 0));
      if (act_of(n))
        check_eq("rd_addr", 32'(rd_addr), 32'(v_of(n) * HA + h_of(n)));
      rec_vld[n % 8] = rd_en;
      rec_addr[n % 8] = int'(rd_addr);
    end else begin
      check_eq("rd_en_idle", 32'(rd_en), 32'd0);
      check_eq("frame_start_idle", 32'(frame_start), 32'd0);
    end
    m = c / DIV - 1 - LAT;
    if (m < 0) begin
      check_eq("rgb_init", 32'({vga_r, vga_g, vga_b}), 32'd0);
      check_eq("hs_init", 32'(vga_hs), 32'd1);
      check_eq("vs_init", 32'(vga_vs), 32'd1);
    end else begin
      h = h_of(m);
      v = v_of(m);
      px = act_of(m) ? mem[v * HA + h] : 8'd0;
      check_eq("rgb", 32'({vga_r, vga_g, vga_b}), 32'(px));
      check_eq("hs", 32'(vga_hs), 32'(!(h >= HA + HF && h < HA + HF + HS)));
      check_eq("vs", 32'(vga_vs), 32'(!(v >= VA + VF && v < VA + VF + VS)));
    end
    check_eq("swap_ack", 32'(swap_ack), 32'(exp_ack));
    check_eq("front_sel", 32'(front_sel), 32'(exp_front));
    if (swap_ack) swap_req = 1'b0;
    if (rise) swap_req = 1'b1;
    rd_data = 8'($urandom);
    if (pce && n >= LAT && rec_vld[(n - LAT) % 8]) begin
      a = rec_addr[(n - LAT) % 8];
      if (a >= 0 && a < HA * VA) rd_data = mem[a];
    end
    exp_ack = pce && h_of(n) == 0 && v_of(n) == VA && swap_req;
    if (exp_ack) exp_front = !exp_front;
    c++;
  endtask

  task automatic run_cycles(input int k);
    int n, fr, v;
    bit rise;
    for (int i = 0; i < k; i++) begin
      n = c / DIV;
      fr = n / FRAME;
      v = v_of(n);
      rise = (fr == 0 && v == 3) || (fr == 1 && v == VA + 1) ||
             (fr >= 3 && $urandom_range(0, 399) == 0);
      do_cycle(rise);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < HA * VA; i++) mem[i] = 8'($urandom);
    model_reset();
    repeat (5) begin
      @(negedge clk);
      check_reset("reset");
    end
    rst_n = 1'b1;
    run_cycles((4 * FRAME + 5 * HT + 10) * DIV);
    rst_n = 1'b0;
    swap_req = 1'b0;
    #1;
    check_reset("async_reset");
    repeat (3) begin
      @(negedge clk);
      check_reset("mid_reset");
    end
    rst_n = 1'b1;
    model_reset();
    run_cycles(2 * FRAME * DIV + 100);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_scanner.md
Name: vga_frame_scanner

Overview:
- Downstream consumer of screen_buffering: reads the front frame buffer in raster order and drives the VGA connector (RGB332 plus HSYNC/VSYNC).
- Generates the 640x480@60 timing from the 50 MHz system clock using an internal pixel clock-enable.
- Compensates for the fixed buffer read latency so that pixel data and sync signals leave the block aligned.
- Owns the front/back buffer swap handshake with screen_buffering; swaps only at the start of vertical blanking so the display never tears.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, HSYNC pulse width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, VSYNC pulse width, in lines
- V_BP, 33, vertical back porch, in lines
- CLK_DIV, 2, clk cycles per pixel (2 or more)
- RD_LAT, 2, buffer read latency in pixel ticks (1..4)
- ADDR_W, 19, buffer address width

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rd_en  out  1  buffer read strobe, one clk wide, on a pixel tick
- rd_addr  out  ADDR_W  pixel address within the front buffer
- rd_data  in  8  RGB332 pixel returned by the buffer
- front_sel  out  1  which buffer is currently displayed (0/1)
- swap_req  in  1  level from screen_buffering: back buffer is complete
- swap_ack  out  1  one-clk pulse: swap performed
- frame_start  out  1  one-clk pulse when h_cnt=0 and v_cnt=0
- vga_r  out  3  red
- vga_g  out  3  green
- vga_b  out  2  blue
- vga_hs  out  1  HSYNC, active low
- vga_vs  out  1  VSYNC, active low

Behaviour:
- **Reset values** (asynchronous, rst_n=0): div=0, h_cnt=0, v_cnt=0, rd_addr=0, front_sel=0.
  - Outputs: rd_en=0, swap_ack=0, frame_start=0, vga_r/g/b=0, vga_hs=1, vga_vs=1.
  - The delay pipeline clears to "blank, syncs inactive".
- **Pixel tick:** div counts 0..CLK_DIV-1 and wraps. pix_ce=1 when div=CLK_DIV-1. All timing state advances only on pix_ce.
- **Counters:**
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - On the h_cnt wrap, v_cnt increments over 0..V_TOTAL-1 (525) and then wraps to 0.
- **Raw timing** (from counters):
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_raw is low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw is low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- **Read issue:**
  - On a pix_ce where active=1: assert rd_en for that clk and present rd_addr.
  - rd_addr then increments by 1 and is not used outside active pixels.
  - At frame start (pix_ce with h_cnt=0, v_cnt=0), rd_addr=0.
  - Address generation is incremental; no multiplier.
  - The last pixel of a frame is address 307199.
- **Alignment:**
  - active, hs_raw and vs_raw pass through an RD_LAT-stage shift register clocked on pix_ce.
  - rd_data is captured on the pix_ce RD_LAT ticks after its rd_en.
  - The output registers update on that same pix_ce.
  - Total latency from counter to pins is RD_LAT+1 pixel ticks, identical for pixel data and both syncs.
- **Blanking:** when the delayed active=0, vga_r/g/b=0 regardless of rd_data.
- **Swap handshake:**
  - Evaluated on the pix_ce where h_cnt=0 and v_cnt=V_ACTIVE (start of vertical blanking).
  - If swap_req=1 at that point: front_sel toggles and swap_ack pulses for exactly one clk.
  - If swap_req=0 there, or it rises later: no swap happens until the next frame's evaluation point.
  - swap_req is held by upstream until it sees swap_ack; at most one swap per frame.
- **frame_start:** one-clk pulse on the pix_ce where h_cnt=0 and v_cnt=0.
- **Reset mid-frame:** all state returns to the reset values immediately; the next frame starts from h_cnt=0, v_cnt=0 with front_sel=0.

Test Plan:
- **Reset and first tick:** hold rst_n=0 for 5 clk, then release. All outputs hold reset values during reset. The first rd_en (addr 0) occurs on the first pix_ce. vga_hs/vs stay 1 for RD_LAT+1 ticks.
- **Line timing:** run 2 lines. vga_hs is low for exactly 96 pixel ticks (192 clk), beginning 656+RD_LAT+1 ticks after frame_start. The line period is 800 ticks (1600 clk).
- **Frame timing and addresses:** run 1 full frame. Exactly 307200 rd_en pulses occur, with addresses 0..307199 in order. vga_vs is low for 2 lines. frame_start repeats every 420000 ticks.
- **Data alignment:** the buffer model returns data = addr[7:0] after RD_LAT ticks. Line 0 pixels 0..639 appear on {vga_r,g,b} as 0x00..0xFF repeating. RGB is 0 during h_cnt 640..799 (delayed).
- **Swap:**
  - Assert swap_req at line 100: swap_ack pulses once at v_cnt=480, front_sel becomes 1.
  - Assert swap_req at line 481: no ack in this frame; the ack comes at the next v_cnt=480.
- **Reset mid-frame:** pull rst_n low at line 200 pixel 300. Outputs reset asynchronously. After release, frame_start pulses on the first pix_ce and rd_addr restarts at 0.
